execute_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline; directly upstream of the memory stage.
- Computes the ALU result, runs a multi-cycle multiply/divide unit (MDU) with HI/LO registers, and owns the EX/MEM pipeline register.
- Its outputs are the memory stage's PC3/Result3/B3/Instr3/WA3/imm32_3 inputs.
- Raises MD_Stall to the hazard unit when an HI/LO-class instruction meets a busy MDU.

---
 rtl/mips_pkg.sv | 84 ++++++++
 rtl/execute_stage_mdu.sv | 112 +++++++++++
 rtl/execute_stage.sv | 121 ++++++++++++
 tb/tb_execute_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings, MDU op and state types; MDU_MADD_EN adds madd/maddu
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;
`ifdef MDU_MADD_EN
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] FN_MADD     = 6'h00;
    localparam logic [5:0] FN_MADDU    = 6'h01;
`endif

    typedef enum logic [2:0] {
        MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU
    } md_op_t;

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    // Instructions that launch a multi-cycle MDU operation.
    function automatic md_op_t md_start_op(input logic [31:0] instr);
        md_op_t op;
        op = MD_NONE;
        if (instr[31:26] == OP_SPECIAL) begin
            case (instr[5:0])
                FN_MULT:  op = MD_MULT;
                FN_MULTU: op = MD_MULTU;
                FN_DIV:   op = MD_DIV;
                FN_DIVU:  op = MD_DIVU;
                default:  op = MD_NONE;
            endcase
        end
`ifdef MDU_MADD_EN
        else if (instr[31:26] == OP_SPECIAL2) begin
            case (instr[5:0])
                FN_MADD:  op = MD_MADD;
                FN_MADDU: op = MD_MADDU;
                default:  op = MD_NONE;
            endcase
        end
`endif
        return op;
    endfunction

    function automatic logic is_md_class(input logic [31:0] instr);
        logic hilo_move;
        hilo_move = (instr[31:26] == OP_SPECIAL) &&
                    (instr[5:0] == FN_MFHI || instr[5:0] == FN_MFLO ||
                     instr[5:0] == FN_MTHI || instr[5:0] == FN_MTLO);
        return hilo_move || (md_start_op(instr) != MD_NONE);
    endfunction

endpackage

// File: rtl/execute_stage_mdu.sv
// rtl/execute_stage_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
module mdu
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  md_op_t      start_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    mdu_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    md_op_t        op_q;
    logic [31:0]   a_q, b_q;
    logic          load, done;

    logic [63:0] prod_s, prod_u, md_res;
    logic        div_signed;
    logic [31:0] dn, dd, dd_safe, quo_m, rem_m, quo, rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= MD_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                op_q <= start_op;
                a_q  <= a;
                b_q  <= b;
            end
            if (done) begin
                {hi, lo} <= md_res;
            end else begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_op != MD_NONE) begin
                    state_next = BUSY;
                    load       = 1'b1;
                    cnt_next   = (start_op == MD_DIV || start_op == MD_DIVU) ?
                                 CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            BUSY: begin
                cnt_next = cnt - CW'(1);
                // Counter reaches zero at this edge: commit and go idle.
                if (cnt == CW'(1)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Signed divide is done on magnitudes; this also yields 0x80000000 / -1 = 0x80000000.
    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'b0, a_q} * {32'b0, b_q};
        div_signed = (op_q == MD_DIV);
        dn         = (div_signed && a_q[31]) ? -a_q : a_q;
        dd         = (div_signed && b_q[31]) ? -b_q : b_q;
        dd_safe    = (dd == 32'd0) ? 32'd1 : dd;
        quo_m      = dn / dd_safe;
        rem_m      = dn % dd_safe;
        quo        = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_m : quo_m;
        rem        = (div_signed && a_q[31]) ? -rem_m : rem_m;
        case (op_q)
            MD_MULT:  md_res = prod_s;
            MD_MULTU: md_res = prod_u;
            MD_DIV,
            MD_DIVU:  md_res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD:  md_res = {hi, lo} + prod_s;
            MD_MADDU: md_res = {hi, lo} + prod_u;
`endif
            default:  md_res = {hi, lo};
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS EX stage: ALU, MDU hookup, EX/MEM register; MDU_MADD_EN enables madd/maddu
module execute_stage
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC2,
    input  logic [31:0] Instr2,
    input  logic [31:0] A2,
    input  logic [31:0] B2,
    input  logic [31:0] imm32_2,
    input  logic [4:0]  WA2,
    output logic        MD_Stall,
    output logic        Busy,
    output logic [31:0] PC3,
    output logic [31:0] Result3,
    output logic [31:0] B3,
    output logic [31:0] Instr3,
    output logic [4:0]  WA3,
    output logic [31:0] imm32_3
);
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt;
    logic [31:0] result, hi, lo;
    logic        is_special;
    md_op_t      start_op;

    assign opcode     = Instr2[31:26];
    assign funct      = Instr2[5:0];
    assign shamt      = Instr2[10:6];
    assign is_special = (opcode == OP_SPECIAL);

    // Stall decision looks only at the instruction in EX, never at EX/MEM.
    assign MD_Stall = Busy && is_md_class(Instr2);
    assign start_op = MD_Stall ? MD_NONE : md_start_op(Instr2);

    mdu #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu (
        .clk     (clk),
        .reset   (reset),
        .start_op(start_op),
        .a       (A2),
        .b       (B2),
        .hi_we   (!MD_Stall && is_special && funct == FN_MTHI),
        .lo_we   (!MD_Stall && is_special && funct == FN_MTLO),
        .wdata   (A2),
        .busy    (Busy),
        .hi      (hi),
        .lo      (lo)
    );

    always_comb begin
        result = '0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU: result = A2 + B2;
                    FN_SUBU: result = A2 - B2;
                    FN_AND:  result = A2 & B2;
                    FN_OR:   result = A2 | B2;
                    FN_XOR:  result = A2 ^ B2;
                    FN_NOR:  result = ~(A2 | B2);
                    FN_SLT:  result = {31'b0, $signed(A2) < $signed(B2)};
                    FN_SLTU: result = {31'b0, A2 < B2};
                    FN_SLL:  result = B2 << shamt;
                    FN_SRL:  result = B2 >> shamt;
                    FN_SRA:  result = $unsigned($signed(B2) >>> shamt);
                    FN_SLLV: result = B2 << A2[4:0];
                    FN_SRLV: result = B2 >> A2[4:0];
                    FN_SRAV: result = $unsigned($signed(B2) >>> A2[4:0]);
                    FN_JALR: result = PC2 + 32'd8;
                    FN_MFHI: result = hi;
                    FN_MFLO: result = lo;
                    default: result = '0;
                endcase
            end
            OP_ADDIU: result = A2 + imm32_2;
            OP_ANDI:  result = A2 & imm32_2;
            OP_ORI:   result = A2 | imm32_2;
            OP_XORI:  result = A2 ^ imm32_2;
            OP_LUI:   result = imm32_2;
            OP_SLTI:  result = {31'b0, $signed(A2) < $signed(imm32_2)};
            OP_SLTIU: result = {31'b0, A2 < imm32_2};
            OP_LW,
            OP_SW:    result = A2 + imm32_2;
            OP_JAL:   result = PC2 + 32'd8;
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC3     <= '0;
            Result3 <= '0;
            B3      <= '0;
            Instr3  <= '0;
            WA3     <= '0;
            imm32_3 <= '0;
        end else if (MD_Stall) begin
            PC3     <= PC2;
            Result3 <= '0;
            B3      <= '0;
            Instr3  <= '0;
            WA3     <= '0;
            imm32_3 <= '0;
        end else begin
            PC3     <= PC2;
            Result3 <= result;
            B3      <= B2;
            Instr3  <= Instr2;
            WA3     <= WA2;
            imm32_3 <= imm32_2;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against a mnemonic-level model
module tb_execute_stage;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC2, Instr2, A2, B2, imm32_2;
    logic [4:0]  WA2;
    logic        MD_Stall, Busy;
    logic [31:0] PC3, Result3, B3, Instr3, imm32_3;
    logic [4:0]  WA3;

    always #5 clk = ~clk;

    execute_stage #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .PC2(PC2), .Instr2(Instr2), .A2(A2), .B2(B2),
        .imm32_2(imm32_2), .WA2(WA2), .MD_Stall(MD_Stall), .Busy(Busy), .PC3(PC3),
        .Result3(Result3), .B3(B3), .Instr3(Instr3), .WA3(WA3), .imm32_3(imm32_3)
    );

    typedef enum int {
        K_ADDU, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU, K_SLL, K_SRL, K_SRA,
        K_SLLV, K_SRLV, K_SRAV, K_ADDIU, K_ANDI, K_ORI, K_XORI, K_LUI, K_SLTI, K_SLTIU,
        K_LW, K_SW, K_JAL, K_JALR, K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_MULT, K_MULTU,
        K_DIV, K_DIVU, K_MADD, K_MADDU, K_BAD
    } kind_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
    int          m_left = 0;
    kind_t       p_kind = K_BAD;
    logic [31:0] p_a = 32'h0, p_b = 32'h0;
    logic        last_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'h1234};
    endfunction

    function automatic logic [31:0] enc(input kind_t k, input logic [4:0] sh);
        case (k)
            K_ADDU:  return rtype(6'h21, 5'd0);
            K_SUBU:  return rtype(6'h23, 5'd0);
            K_AND:   return rtype(6'h24, 5'd0);
            K_OR:    return rtype(6'h25, 5'd0);
            K_XOR:   return rtype(6'h26, 5'd0);
            K_NOR:   return rtype(6'h27, 5'd0);
            K_SLT:   return rtype(6'h2A, 5'd0);
            K_SLTU:  return rtype(6'h2B, 5'd0);
            K_SLL:   return rtype(6'h00, sh);
            K_SRL:   return rtype(6'h02, sh);
            K_SRA:   return rtype(6'h03, sh);
            K_SLLV:  return rtype(6'h04, 5'd0);
            K_SRLV:  return rtype(6'h06, 5'd0);
            K_SRAV:  return rtype(6'h07, 5'd0);
            K_JALR:  return rtype(6'h09, 5'd0);
            K_MFHI:  return rtype(6'h10, 5'd0);
            K_MTHI:  return rtype(6'h11, 5'd0);
            K_MFLO:  return rtype(6'h12, 5'd0);
            K_MTLO:  return rtype(6'h13, 5'd0);
            K_MULT:  return rtype(6'h18, 5'd0);
            K_MULTU: return rtype(6'h19, 5'd0);
            K_DIV:   return rtype(6'h1A, 5'd0);
            K_DIVU:  return rtype(6'h1B, 5'd0);
            K_ADDIU: return itype(6'h09);
            K_SLTI:  return itype(6'h0A);
            K_SLTIU: return itype(6'h0B);
            K_ANDI:  return itype(6'h0C);
            K_ORI:   return itype(6'h0D);
            K_XORI:  return itype(6'h0E);
            K_LUI:   return itype(6'h0F);
            K_LW:    return itype(6'h23);
            K_SW:    return itype(6'h2B);
            K_JAL:   return {6'h03, 26'h0000040};
            K_MADD:  return {6'h1C, 5'd1, 5'd2, 10'd0, 6'h00};
            K_MADDU: return {6'h1C, 5'd1, 5'd2, 10'd0, 6'h01};
            default: return {6'h3F, 26'h0};
        endcase
    endfunction

    function automatic logic madd_on();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic is_start(input kind_t k);
        return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU} ||
               (madd_on() && k inside {K_MADD, K_MADDU});
    endfunction

    function automatic logic is_md(input kind_t k);
        return is_start(k) || k inside {K_MFHI, K_MFLO, K_MTHI, K_MTLO};
    endfunction

    function automatic logic [31:0] model_result(input kind_t k, input logic [31:0] a, b, imm, pc,
                                                 input logic [4:0] sh, input logic [31:0] hi, lo);
        logic signed [31:0] sb;
        sb = b;
        case (k)
            K_ADDU:  return a + b;
            K_SUBU:  return a - b;
            K_AND:   return a & b;
            K_OR:    return a | b;
            K_XOR:   return a ^ b;
            K_NOR:   return ~(a | b);
            K_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            K_SLL:   return b << sh;
            K_SRL:   return b >> sh;
            K_SRA:   return sb >>> sh;
            K_SLLV:  return b << a[4:0];
            K_SRLV:  return b >> a[4:0];
            K_SRAV:  return sb >>> a[4:0];
            K_ADDIU: return a + imm;
            K_ANDI:  return a & imm;
            K_ORI:   return a | imm;
            K_XORI:  return a ^ imm;
            K_LUI:   return imm;
            K_SLTI:  return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            K_SLTIU: return (a < imm) ? 32'd1 : 32'd0;
            K_LW, K_SW:   return a + imm;
            K_JAL, K_JALR: return pc + 32'd8;
            K_MFHI:  return hi;
            K_MFLO:  return lo;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] md_apply(input kind_t k, input logic [31:0] a, b,
                                             input logic [63:0] acc);
        longint sa, sb, q, rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (k)
            K_MULT:  return sa * sb;
            K_MULTU: return {32'h0, a} * {32'h0, b};
            K_MADD:  return acc + sa * sb;
            K_MADDU: return acc + {32'h0, a} * {32'h0, b};
            K_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            K_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    task automatic step(input kind_t k, input logic [31:0] a, b, imm, pc,
                        input logic [4:0] wa, sh, input logic rst);
        logic [31:0] ins, res;
        logic        stall;
        ins   = enc(k, sh);
        @(negedge clk);
        reset = rst; PC2 = pc; Instr2 = ins; A2 = a; B2 = b; imm32_2 = imm; WA2 = wa;
        stall = (m_left > 0) && is_md(k);
        res   = model_result(k, a, b, imm, pc, sh, m_hi, m_lo);
        #1;
        chk("md_stall", {31'b0, MD_Stall}, {31'b0, stall});
        @(posedge clk);
        #1;
        if (rst) begin
            m_hi = 32'h0; m_lo = 32'h0; m_left = 0;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) {m_hi, m_lo} = md_apply(p_kind, p_a, p_b, {m_hi, m_lo});
            end
            if (!stall) begin
                if (is_start(k)) begin
                    p_kind = k; p_a = a; p_b = b;
                    m_left = (k == K_DIV || k == K_DIVU) ? DIV_CYCLES : MULT_CYCLES;
                end
                if (k == K_MTHI) m_hi = a;
                if (k == K_MTLO) m_lo = a;
            end
        end
        last_stall = stall;
        chk("busy", {31'b0, Busy}, {31'b0, (m_left > 0)});
        chk("pc3", PC3, rst ? 32'h0 : pc);
        chk("result3", Result3, (rst || stall) ? 32'h0 : res);
        chk("b3", B3, (rst || stall) ? 32'h0 : b);
        chk("instr3", Instr3, (rst || stall) ? 32'h0 : ins);
        chk("wa3", {27'b0, WA3}, (rst || stall) ? 32'h0 : {27'b0, wa});
        chk("imm32_3", imm32_3, (rst || stall) ? 32'h0 : imm);
    endtask

    task automatic held(input kind_t k, input logic [31:0] a, output int n);
        logic [31:0] pc;
        pc = $urandom;
        n  = 0;
        do begin
            step(k, a, 32'h0, 32'h0, pc, 5'd4, 5'd0, 1'b0);
            n++;
        end while (last_stall && n < 40);
    endtask

    initial begin
        int          n;
        kind_t       k;
        logic [31:0] a, b, imm, pc;
        logic [4:0]  wa, sh;
        reset = 1'b1; PC2 = '0; Instr2 = '0; A2 = '0; B2 = '0; imm32_2 = '0; WA2 = '0;
        step(K_BAD, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
        step(K_ADDU, 32'h5, 32'h6, 32'h7, 32'h100, 5'd2, 5'd0, 1'b1);

        step(K_ADDU, 32'd7, 32'hFFFF_FFFF, 32'h0, 32'h200, 5'd3, 5'd0, 1'b0);
        chk("addu_const", Result3, 32'd6);

        step(K_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0, 32'h300, 5'd0, 5'd0, 1'b0);
        held(K_MFLO, 32'h0, n);
        chk("mult_stall_steps", n, MULT_CYCLES + 1);
        chk("mflo_const", Result3, 32'hFFFF_FFF1);
        step(K_MFHI, 32'h0, 32'h0, 32'h0, 32'h310, 5'd5, 5'd0, 1'b0);
        chk("mfhi_const", Result3, 32'hFFFF_FFFF);

        step(K_DIV, 32'd10, 32'd0, 32'h0, 32'h400, 5'd0, 5'd0, 1'b0);
        held(K_MFHI, 32'h0, n);
        chk("div_stall_steps", n, DIV_CYCLES + 1);
        chk("div0_hi", Result3, 32'd10);
        step(K_MFLO, 32'h0, 32'h0, 32'h0, 32'h410, 5'd5, 5'd0, 1'b0);
        chk("div0_lo", Result3, 32'hFFFF_FFFF);

        step(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h500, 5'd0, 5'd0, 1'b0);
        held(K_MFLO, 32'h0, n);
        chk("div_ovf_lo", Result3, 32'h8000_0000);
        step(K_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h510, 5'd0, 5'd0, 1'b0);
        held(K_MFHI, 32'h0, n);
        chk("div_neg_rem", Result3, 32'hFFFF_FFFF);

        step(K_MULTU, 32'h1234, 32'h5678, 32'h0, 32'h600, 5'd0, 5'd0, 1'b0);
        step(K_ADDU, 32'd1, 32'd2, 32'h0, 32'h604, 5'd6, 5'd0, 1'b0);
        step(K_LW, 32'h1000, 32'h0, 32'h24, 32'h608, 5'd7, 5'd0, 1'b0);
        chk("lw_addr", Result3, 32'h1024);
        chk("busy_in_flight", {31'b0, Busy}, 32'd1);
        held(K_MFLO, 32'h0, n);

        step(K_MTHI, 32'h1234, 32'h0, 32'h0, 32'h700, 5'd0, 5'd0, 1'b0);
        step(K_MFHI, 32'h0, 32'h0, 32'h0, 32'h704, 5'd8, 5'd0, 1'b0);
        chk("mthi_mfhi", Result3, 32'h1234);

        step(K_DIV, 32'd100, 32'd7, 32'h0, 32'h800, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(K_ADDU, 32'd1, 32'd1, 32'h0, 32'h804, 5'd1, 5'd0, 1'b0);
        step(K_ADDU, 32'd1, 32'd1, 32'h0, 32'h808, 5'd1, 5'd0, 1'b1);
        chk("reset_busy", {31'b0, Busy}, 32'd0);
        step(K_MFHI, 32'h0, 32'h0, 32'h0, 32'h80C, 5'd2, 5'd0, 1'b0);
        chk("reset_hi", Result3, 32'h0);
        step(K_MFLO, 32'h0, 32'h0, 32'h0, 32'h810, 5'd2, 5'd0, 1'b0);
        chk("reset_lo", Result3, 32'h0);

        step(K_MTHI, 32'h0, 32'h0, 32'h0, 32'h900, 5'd0, 5'd0, 1'b0);
        step(K_MTLO, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h904, 5'd0, 5'd0, 1'b0);
        step(K_MADDU, 32'd1, 32'd1, 32'h0, 32'h908, 5'd0, 5'd0, 1'b0);
        held(K_MFHI, 32'h0, n);
`ifdef MDU_MADD_EN
        chk("madd_stall_steps", n, MULT_CYCLES + 1);
        chk("maddu_hi", Result3, 32'd1);
        step(K_MFLO, 32'h0, 32'h0, 32'h0, 32'h910, 5'd2, 5'd0, 1'b0);
        chk("maddu_lo", Result3, 32'd0);
`else
        chk("madd_off_steps", n, 1);
        chk("madd_off_hi", Result3, 32'd0);
        step(K_MFLO, 32'h0, 32'h0, 32'h0, 32'h910, 5'd2, 5'd0, 1'b0);
        chk("madd_off_lo", Result3, 32'hFFFF_FFFF);
`endif

        k = K_ADDU; a = '0; b = '0; imm = '0; pc = '0; wa = '0; sh = '0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                k   = kind_t'($urandom_range(0, int'(K_BAD)));
                a   = $urandom;
                b   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                imm = $urandom;
                pc  = $urandom;
                wa  = 5'($urandom);
                sh  = 5'($urandom);
            end
            step(k, a, b, imm, pc, wa, sh, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
